n1_sagu_mc: RTL and testbench

Multi-channel stack bus address generation unit for the N1 core. It succeeds the two-stack AGU and holds STACK_CNT stack pointers internally instead of borrowing the DSP adders. Each pointer owns an equal, fixed partition of the stack bus address space. The block accepts push/pull/load/reset requests from the PRS through a valid/ready handshake. It runs the matching single-beat stack bus (wishbone) cycle and reports empty, near-full and refused-operation conditions to PRS and EXCPT.

---
 rtl/n1_sagu_pkg.sv | 19 +
 rtl/n1_sagu_sp.sv | 51 +++++
 rtl/n1_sagu_mc.sv | 165 ++++++++++++++++
 tb/tb_n1_sagu_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/n1_sagu_pkg.sv
// Shared types for the N1 multi-channel stack address generation unit.
// The package holds the PRS request opcode encoding and the FSM state enum.
package n1_sagu_pkg;

  // Opcode carried by a PRS request.
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_PULL = 2'b01,
    OP_LOAD = 2'b10,
    OP_RST  = 2'b11
  } sagu_op_e;

  // ST_BUS: a stack bus cycle is outstanding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } sagu_state_e;

endpackage

// File: rtl/n1_sagu_sp.sv
// A single stack pointer with its boundary compares.
// Ports:
//   clk_i, async_rst_i                   clock, async active-low reset
//   inc_i, dec_i, load_i, clr_i          per-stack update strobes from the FSM
//   load_val_i                           value taken when load_i is set
//   sp_o                                 registered pointer
//   empty_o, full_o, nfull_o             combinational compares on sp_o
module n1_sagu_sp
  import n1_sagu_pkg::*;
#(
  parameter int unsigned LSP_WIDTH   = 11,
  parameter int unsigned SAFETY_DIST = 22
) (
  input  logic                 clk_i,
  input  logic                 async_rst_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic [LSP_WIDTH-1:0] load_val_i,
  output logic [LSP_WIDTH-1:0] sp_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 nfull_o
);

  localparam logic [LSP_WIDTH-1:0] SP_MAX   = '1;
  localparam logic [LSP_WIDTH-1:0] NFULL_TH = LSP_WIDTH'((2 ** LSP_WIDTH) - SAFETY_DIST);

  logic [LSP_WIDTH-1:0] sp_q, sp_d;

  // The FSM never raises more than one strobe per cycle; priority is defensive.
  always_comb begin
    sp_d = sp_q;
    if (clr_i)       sp_d = '0;
    else if (load_i) sp_d = load_val_i;
    else if (inc_i)  sp_d = sp_q + LSP_WIDTH'(1);
    else if (dec_i)  sp_d = sp_q - LSP_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) sp_q <= '0;
    else              sp_q <= sp_d;
  end

  assign sp_o    = sp_q;
  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SP_MAX);
  assign nfull_o = (sp_q >= NFULL_TH);

endmodule

// File: rtl/n1_sagu_mc.sv
// Multi-channel stack bus AGU: STACK_CNT pointers, each owning an equal
// partition of the stack bus address space, serviced via single-beat
// wishbone cycles.
// Ports:
//   clk_i, async_rst_i                 clock, async active-low reset
//   prs2sagu_req_i / sagu2prs_rdy_o    request handshake
//   prs2sagu_stack_sel_i, _op_i, _load_val_i   request payload
//   sagu2prs_empty_o, sagu2prs_sp_o    per-stack status (stack 0 in LSBs)
//   sagu2excpt_nfull_o                 per-stack near-full
//   sagu2excpt_of_o, sagu2excpt_uf_o   refused push / pull pulses
//   sbus_*                             wishbone master (cyc, stb, we, adr, tga, ack)
module n1_sagu_mc
  import n1_sagu_pkg::*;
#(
  parameter  int unsigned SP_WIDTH    = 12,
  parameter  int unsigned STACK_CNT   = 2,
  parameter  int unsigned SAFETY_DIST = 22,
  localparam int unsigned IDW         = $clog2(STACK_CNT),
  localparam int unsigned LSP_WIDTH   = SP_WIDTH - IDW
) (
  input  logic                           clk_i,
  input  logic                           async_rst_i,
  input  logic                           prs2sagu_req_i,
  output logic                           sagu2prs_rdy_o,
  input  logic [IDW-1:0]                 prs2sagu_stack_sel_i,
  input  logic [1:0]                     prs2sagu_op_i,
  input  logic [LSP_WIDTH-1:0]           prs2sagu_load_val_i,
  output logic [STACK_CNT-1:0]           sagu2prs_empty_o,
  output logic [STACK_CNT*LSP_WIDTH-1:0] sagu2prs_sp_o,
  output logic [STACK_CNT-1:0]           sagu2excpt_nfull_o,
  output logic [STACK_CNT-1:0]           sagu2excpt_of_o,
  output logic [STACK_CNT-1:0]           sagu2excpt_uf_o,
  output logic                           sbus_cyc_o,
  output logic                           sbus_stb_o,
  output logic                           sbus_we_o,
  output logic [SP_WIDTH-1:0]            sbus_adr_o,
  output logic [IDW-1:0]                 sbus_tga_o,
  input  logic                           sbus_ack_i
);

  sagu_state_e          state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [SP_WIDTH-1:0]  adr_q, adr_d;
  logic [IDW-1:0]       tga_q, tga_d;
  logic [STACK_CNT-1:0] of_q, of_d, uf_q, uf_d;
  logic [STACK_CNT-1:0] inc_w, dec_w, load_w, clr_w, full_w;
  logic [LSP_WIDTH-1:0] sp_w [STACK_CNT];
  sagu_op_e             op_w;

  assign op_w = sagu_op_e'(prs2sagu_op_i);

  // Pointer bank, one instance per stack.
  for (genvar g = 0; g < STACK_CNT; g++) begin : g_sp
    n1_sagu_sp #(
      .LSP_WIDTH   (LSP_WIDTH),
      .SAFETY_DIST (SAFETY_DIST)
    ) u_sp (
      .clk_i       (clk_i),
      .async_rst_i (async_rst_i),
      .inc_i       (inc_w[g]),
      .dec_i       (dec_w[g]),
      .load_i      (load_w[g]),
      .clr_i       (clr_w[g]),
      .load_val_i  (prs2sagu_load_val_i),
      .sp_o        (sp_w[g]),
      .empty_o     (sagu2prs_empty_o[g]),
      .full_o      (full_w[g]),
      .nfull_o     (sagu2excpt_nfull_o[g])
    );
    assign sagu2prs_sp_o[g*LSP_WIDTH +: LSP_WIDTH] = sp_w[g];
  end

  // Next-state, bus payload and per-stack strobes.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    tga_d   = tga_q;
    of_d    = '0;
    uf_d    = '0;
    inc_w   = '0;
    dec_w   = '0;
    load_w  = '0;
    clr_w   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (prs2sagu_req_i) begin
          unique case (op_w)
            OP_PUSH: begin
              if (full_w[prs2sagu_stack_sel_i]) begin
                of_d[prs2sagu_stack_sel_i] = 1'b1;
              end else begin
                state_d = ST_BUS;
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = {prs2sagu_stack_sel_i, sp_w[prs2sagu_stack_sel_i]};
                tga_d   = prs2sagu_stack_sel_i;
              end
            end
            OP_PULL: begin
              if (sp_w[prs2sagu_stack_sel_i] == '0) begin
                uf_d[prs2sagu_stack_sel_i] = 1'b1;
              end else begin
                state_d = ST_BUS;
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                // Pull reads the topmost occupied word, one below SP.
                adr_d   = {prs2sagu_stack_sel_i,
                           sp_w[prs2sagu_stack_sel_i] - LSP_WIDTH'(1)};
                tga_d   = prs2sagu_stack_sel_i;
              end
            end
            OP_LOAD: load_w[prs2sagu_stack_sel_i] = 1'b1;
            OP_RST:  clr_w[prs2sagu_stack_sel_i]  = 1'b1;
            default: ;
          endcase
        end
      end
      ST_BUS: begin
        if (sbus_ack_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          if (we_q) inc_w[tga_q] = 1'b1;
          else      dec_w[tga_q] = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      tga_q   <= '0;
      of_q    <= '0;
      uf_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      tga_q   <= tga_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
    end
  end

  assign sagu2prs_rdy_o  = (state_q == ST_IDLE);
  assign sagu2excpt_of_o = of_q;
  assign sagu2excpt_uf_o = uf_q;
  assign sbus_cyc_o      = cyc_q;
  assign sbus_stb_o      = cyc_q;
  assign sbus_we_o       = we_q;
  assign sbus_adr_o      = adr_q;
  assign sbus_tga_o      = tga_q;

endmodule

// File: tb/tb_n1_sagu_mc.sv
// Self-checking bench for n1_sagu_mc: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_n1_sagu_mc;

  localparam int unsigned SPW   = 12;
  localparam int unsigned NSTK  = 2;
  localparam int unsigned SDIST = 22;
  localparam int unsigned IDW   = 1;
  localparam int unsigned LSPW  = 11;
  localparam int          SPMAX = 2047;
  localparam int          NFTH  = 2048 - 22;

  logic             clk_i = 1'b0;
  logic             rst_n;
  logic             req = 1'b0;
  logic             rdy;
  logic [IDW-1:0]   sel = '0;
  logic [1:0]       op = 2'b00;
  logic [LSPW-1:0]  lv = '0;
  logic [NSTK-1:0]  empty, nfull, of_p, uf_p;
  logic [NSTK*LSPW-1:0] sp_bus;
  logic             cyc, stb, we, ack = 1'b0;
  logic [SPW-1:0]   adr;
  logic [IDW-1:0]   tga;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  n1_sagu_mc #(.SP_WIDTH(SPW), .STACK_CNT(NSTK), .SAFETY_DIST(SDIST)) dut (
    .clk_i                (clk_i),
    .async_rst_i          (rst_n),
    .prs2sagu_req_i       (req),
    .sagu2prs_rdy_o       (rdy),
    .prs2sagu_stack_sel_i (sel),
    .prs2sagu_op_i        (op),
    .prs2sagu_load_val_i  (lv),
    .sagu2prs_empty_o     (empty),
    .sagu2prs_sp_o        (sp_bus),
    .sagu2excpt_nfull_o   (nfull),
    .sagu2excpt_of_o      (of_p),
    .sagu2excpt_uf_o      (uf_p),
    .sbus_cyc_o           (cyc),
    .sbus_stb_o           (stb),
    .sbus_we_o            (we),
    .sbus_adr_o           (adr),
    .sbus_tga_o           (tga),
    .sbus_ack_i           (ack)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: integer pointers plus an outstanding-bus descriptor.
  int m_sp [NSTK];
  bit m_busy = 1'b0;
  bit m_we   = 1'b0;
  int m_adr  = 0;
  int m_tga  = 0;
  int m_of   = 0;
  int m_uf   = 0;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTK; i++) m_sp[i] = 0;
      m_busy = 1'b0; m_we = 1'b0; m_adr = 0; m_tga = 0; m_of = 0; m_uf = 0;
    end else begin
      m_of = 0;
      m_uf = 0;
      if (m_busy) begin
        if (ack) begin
          m_sp[m_tga] = m_sp[m_tga] + (m_we ? 1 : -1);
          m_busy = 1'b0;
        end
      end else if (req) begin
        case (op)
          2'd0: if (m_sp[sel] == SPMAX) m_of = 1 << sel;
                else begin
                  m_busy = 1'b1; m_we = 1'b1; m_tga = int'(sel);
                  m_adr = int'(sel) * 2048 + m_sp[sel];
                end
          2'd1: if (m_sp[sel] == 0) m_uf = 1 << sel;
                else begin
                  m_busy = 1'b1; m_we = 1'b0; m_tga = int'(sel);
                  m_adr = int'(sel) * 2048 + m_sp[sel] - 1;
                end
          2'd2: m_sp[sel] = int'(lv);
          default: m_sp[sel] = 0;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (chk_en && rst_n) begin
      int exp_empty, exp_nfull, exp_sp;
      exp_empty = 0; exp_nfull = 0; exp_sp = 0;
      for (int i = 0; i < NSTK; i++) begin
        if (m_sp[i] == 0)     exp_empty |= (1 << i);
        if (m_sp[i] >= NFTH)  exp_nfull |= (1 << i);
        exp_sp |= m_sp[i] << (i * LSPW);
      end
      chk("rdy",   32'(rdy),    32'(!m_busy));
      chk("cyc",   32'(cyc),    32'(m_busy));
      chk("stb",   32'(stb),    32'(m_busy));
      chk("sp",    32'(sp_bus), 32'(exp_sp));
      chk("empty", 32'(empty),  32'(exp_empty));
      chk("nfull", 32'(nfull),  32'(exp_nfull));
      chk("of",    32'(of_p),   32'(m_of));
      chk("uf",    32'(uf_p),   32'(m_uf));
      if (m_busy) begin
        chk("we",  32'(we),  32'(m_we));
        chk("adr", 32'(adr), 32'(m_adr));
        chk("tga", 32'(tga), 32'(m_tga));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input int s, input int v);
    req = 1'b1; op = o; sel = IDW'(s); lv = LSPW'(v);
    tick();
    req = 1'b0;
  endtask

  function automatic int sp_of(input int s);
    logic [NSTK*LSPW-1:0] b;
    b = sp_bus;
    return int'(b[s*LSPW +: LSPW]);
  endfunction

  initial begin
    rst_n = 1'b0;
    #12;
    // Reset state, literal.
    chk("rst_rdy",   32'(rdy),   32'd1);
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_nfull", 32'(nfull), 32'h0);
    chk("rst_cyc",   32'(cyc),   32'd0);
    chk("rst_adr",   32'(adr),   32'd0);
    chk("rst_tga",   32'(tga),   32'd0);
    chk("rst_we",    32'(we),    32'd0);
    chk("rst_ofuf",  32'({of_p, uf_p}), 32'd0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Push to stack 1, ack one cycle after stb.
    issue(2'd0, 1, 0);
    chk("push_stb", 32'(stb), 32'd1);
    chk("push_adr", 32'(adr), 32'h800);
    chk("push_we",  32'(we),  32'd1);
    chk("push_tga", 32'(tga), 32'd1);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("push_sp1",   32'(sp_of(1)), 32'd1);
    chk("push_empty", 32'(empty),    32'h1);
    chk("push_cyc",   32'(cyc),      32'd0);

    // Load stack 0 with 5, pull with ack delayed 3 cycles.
    issue(2'd2, 0, 5);
    chk("load_sp0", 32'(sp_of(0)), 32'd5);
    issue(2'd1, 0, 0);
    chk("pull_adr", 32'(adr), 32'h004);
    chk("pull_we",  32'(we),  32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("pull_hold_stb", 32'(stb), 32'd1);
      chk("pull_hold_rdy", 32'(rdy), 32'd0);
      tick();
    end
    chk("pull_stb4", 32'(stb), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("pull_sp0", 32'(sp_of(0)), 32'd4);
    chk("pull_done", 32'(cyc), 32'd0);

    // Clear stack 0, then pull on empty stack 0.
    issue(2'd3, 0, 0);
    issue(2'd1, 0, 0);
    chk("uf_pulse", 32'(uf_p), 32'h1);
    chk("uf_cyc",   32'(cyc),  32'd0);
    tick();
    chk("uf_clear", 32'(uf_p), 32'h0);
    chk("uf_sp0",   32'(sp_of(0)), 32'd0);

    // Full stack 1: refused push, then near-full threshold crossing.
    issue(2'd2, 1, 2047);
    issue(2'd0, 1, 0);
    chk("of_pulse", 32'(of_p), 32'h2);
    chk("of_cyc",   32'(cyc),  32'd0);
    tick();
    chk("of_clear", 32'(of_p), 32'h0);
    chk("of_sp1",   32'(sp_of(1)), 32'd2047);
    issue(2'd2, 1, 2025);
    chk("nf_before", 32'(nfull), 32'h0);
    issue(2'd0, 1, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("nf_sp1",  32'(sp_of(1)), 32'd2026);
    chk("nf_after", 32'(nfull), 32'h2);

    // Back-to-back loads/resets on alternating stacks.
    req = 1'b1; op = 2'd2; sel = 1'b0; lv = 11'd7;
    tick(); chk("b2b_rdy0", 32'(rdy), 32'd1);
    op = 2'd2; sel = 1'b1; lv = 11'd9;
    tick(); chk("b2b_rdy1", 32'(rdy), 32'd1);
    op = 2'd3; sel = 1'b0;
    tick(); req = 1'b0;
    chk("b2b_sp", 32'(sp_bus), 32'({11'd9, 11'd0}));

    // Reset asserted mid-bus aborts the cycle; later ack is ignored.
    issue(2'd0, 0, 0);
    chk("abort_cyc_pre", 32'(cyc), 32'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_cyc", 32'(cyc), 32'd0);
    chk("abort_stb", 32'(stb), 32'd0);
    chk("abort_sp",  32'(sp_bus), 32'd0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    ack = 1'b1;
    tick(); tick(); tick();
    ack = 1'b0;
    chk("abort_ack_sp",  32'(sp_bus), 32'd0);
    chk("abort_ack_cyc", 32'(cyc),    32'd0);

    // Randomized traffic, with load values biased toward the boundaries.
    for (int c = 0; c < 3000; c++) begin
      int pick;
      req = ($urandom_range(0, 99) < 70);
      sel = IDW'($urandom_range(0, NSTK - 1));
      pick = $urandom_range(0, 9);
      op = (pick < 4) ? 2'd0 : (pick < 7) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      case ($urandom_range(0, 6))
        0: lv = 11'd0;
        1: lv = 11'd1;
        2: lv = 11'd2046;
        3: lv = 11'd2047;
        4: lv = 11'd2025;
        5: lv = 11'd2026;
        default: lv = LSPW'($urandom);
      endcase
      ack = ($urandom_range(0, 99) < 40);
      tick();
    end
    req = 1'b0;
    ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
